// File: rtl/mem_arb_pkg.sv
// Shared control constants for the processor memory path: arbiter state
// encoding, datapath widths and the default fetch starvation limit.
package mem_arb_pkg;

  localparam int unsigned WORD_W           = 16;
  localparam int unsigned WAIT_W           = 3;
  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    HALTED  = 2'd3
  } arbState_t;

  // Word accesses only; an odd address cannot be issued to memory.
  function automatic logic isUnaligned(input logic [WORD_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Fetch starvation counter: counts data grants taken while a fetch is
// waiting, saturating at MAX_WAIT; any fetch grant clears it.
module arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ifReq,
  input  logic ifGrant,
  input  logic dmGrant,
  output logic atMax
);

  localparam logic [WAIT_W-1:0] MaxCnt = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt;

  // Count data grants that bypass a pending fetch; clear when the fetch wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ifGrant) begin
      cnt <= '0;
    end else if (dmGrant && ifReq && (cnt != MaxCnt)) begin
      cnt <= cnt + WAIT_W'(1);
    end
  end

  assign atMax = (cnt == MaxCnt);

endmodule

// File: rtl/mem_arb.sv
// Two-requester memory arbiter: instruction fetch and data access share one
// single-outstanding memory port. Data has priority, bounded by a fetch
// starvation limit; halt parks the arbiter until reset.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [WORD_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              halt,
  output logic              halted,
  output logic              err
);

  arbState_t state;
  logic      grantIf;
  logic      grantDm;
  logic      starved;
  logic      busy;

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) waitCnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ifReq  (if_req),
    .ifGrant(grantIf),
    .dmGrant(grantDm),
    .atMax  (starved)
  );

  // Grant decision while idle: halt outranks both, data outranks a non-starved fetch
  always_comb begin
    grantIf = 1'b0;
    grantDm = 1'b0;
    if ((state == IDLE) && !halt) begin
      if (dm_req && !(if_req && starved)) begin
        grantDm = 1'b1;
      end else if (if_req) begin
        grantIf = 1'b1;
      end
    end
  end

  // Arbiter FSM with registered memory strobes; mem_en and err are one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      halted    <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (grantDm) begin
            state     <= BUSY_DM;
            mem_wr    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wr ? dm_wdata : '0;
            if (isUnaligned(dm_addr)) err <= 1'b1;
            else                      mem_en <= 1'b1;
          end else if (grantIf) begin
            state     <= BUSY_IF;
            mem_wr    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            if (isUnaligned(if_addr)) err <= 1'b1;
            else                      mem_en <= 1'b1;
          end
        end
        BUSY_IF, BUSY_DM: begin
          // err marks a rejected access that completes in its first cycle
          if (mem_done || err) state <= IDLE;
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY_IF) || (state == BUSY_DM);

  // Completion follows mem_done directly; err stands in for it on a rejected access
  assign if_done = (state == BUSY_IF) && (mem_done || err);
  assign dm_done = (state == BUSY_DM) && (mem_done || err);
  assign rdata   = busy ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios followed by a randomized phase
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arb;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_done;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_done;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic        halt = 1'b0;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  mem_arb #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .rdata(rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .halt(halt), .halted(halted), .err(err)
  );

  int unsigned nChecks = 0;
  int unsigned nPass   = 0;
  int unsigned nFail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: one outstanding access, fixed or random latency after mem_en
  logic [15:0] memArr [logic [15:0]];
  logic [15:0] shadow [logic [15:0]];
  int unsigned memLat = 1;
  bit          memRandLat = 1'b0;
  int unsigned memCnt = 0;
  logic [15:0] memData = '0;

  always @(posedge clk) begin
    #1;
    mem_done  = 1'b0;
    mem_rdata = 16'($urandom);
    if (memCnt != 0) begin
      memCnt--;
      if (memCnt == 0) begin
        mem_done  = 1'b1;
        mem_rdata = memData;
      end
    end
    if (mem_en) begin
      memCnt = memRandLat ? $urandom_range(1, 4) : memLat;
      if (mem_wr) begin
        memArr[mem_addr] = mem_wdata;
        memData = 16'($urandom);
      end else begin
        memData = memArr.exists(mem_addr) ? memArr[mem_addr] : (mem_addr ^ 16'h5A5A);
      end
    end
  end

  function automatic logic [15:0] expRead(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : (a ^ 16'h5A5A);
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  task automatic waitFor(input bit forDm, input int unsigned bound,
                         output int unsigned cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < bound) begin
      tick();
      mid();
      cycles++;
      if (forDm ? dm_done : if_done) got = 1'b1;
    end
  endtask

  function automatic logic [15:0] rndAddr();
    logic [15:0] a;
    a = 16'h0100 | 16'($urandom_range(0, 15) << 1);
    if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
    return a;
  endfunction

  task automatic newIf();
    if_req  = 1'b1;
    if_addr = rndAddr();
  endtask

  task automatic newDm();
    dm_req   = 1'b1;
    dm_wr    = 1'($urandom_range(0, 1));
    dm_addr  = rndAddr();
    dm_wdata = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    bit          got;
    int unsigned dmGrants;
    bit          ifSeen;
    int unsigned bad;
    int unsigned grantKind, kindThis, carryKind, lastDone, waitModel;
    bit          prevIdle, pIf, pDm, busyCarry, busyThis, doneNow, unal, expEn;

    memArr[16'h0010] = 16'hD0AF;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_wr", mem_wr, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_done", if_done, 0);
    chk("rst dm_done", dm_done, 0);
    chk("rst err", err, 0);
    chk("rst halted", halted, 0);
    tick(); rst_n = 1'b1;
    mid(); tick();

    // Fetch only, memory answers 3 cycles after mem_en
    memLat = 3; if_addr = 16'h0010; if_req = 1'b1;
    mid(); chk("fetch no early en", mem_en, 0);
    tick(); mid();
    chk("fetch mem_en", mem_en, 1);
    chk("fetch mem_addr", mem_addr, 16'h0010);
    chk("fetch mem_wr", mem_wr, 0);
    chk("fetch mem_wdata", mem_wdata, 0);
    waitFor(1'b0, 20, n, got);
    chk("fetch done seen", got, 1);
    chk("fetch done delay", n, 3);
    chk("fetch rdata", rdata, 16'hD0AF);
    tick(); if_req = 1'b0;
    mid(); chk("fetch done one pulse", if_done, 0);

    // Simultaneous requests: store wins, fetch after one idle cycle
    tick();
    memLat = 1;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0030;
    mid(); tick(); mid();
    chk("both dm first en", mem_en, 1);
    chk("both dm wr", mem_wr, 1);
    chk("both dm addr", mem_addr, 16'h0020);
    chk("both dm wdata", mem_wdata, 16'h1234);
    tick(); mid();
    chk("both dm_done", dm_done, 1);
    chk("both no if_done", if_done, 0);
    tick(); dm_req = 1'b0;
    mid(); chk("both idle gap", mem_en, 0);
    tick(); mid();
    chk("both if en", mem_en, 1);
    chk("both if addr", mem_addr, 16'h0030);
    waitFor(1'b0, 20, n, got);
    chk("both if done", got, 1);
    tick(); if_req = 1'b0;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
    mid();
    waitFor(1'b1, 20, n, got);
    chk("load done seen", got, 1);
    chk("load min latency", n, 2);
    chk("load readback", rdata, 16'h1234);
    tick(); dm_req = 1'b0;
    mid(); tick();

    // Starvation limit: held data requests, fetch waits MAX_WAIT grants
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    if_req = 1'b1; if_addr = 16'h0042;
    dmGrants = 0; ifSeen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      mid();
      if (mem_en) begin
        if (!mem_wr && mem_addr == 16'h0042) begin
          ifSeen = 1'b1;
          break;
        end
        dmGrants++;
      end
      tick();
    end
    chk("starve if granted", ifSeen, 1);
    chk("starve dm grants", dmGrants, MAXW);
    waitFor(1'b0, 20, n, got);
    chk("starve if done", got, 1);
    tick(); if_req = 1'b0; dm_req = 1'b0;
    mid(); tick();

    // Unaligned load: no mem_en, dm_done with err in the grant cycle
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0021;
    mid(); chk("unal no early done", dm_done, 0);
    tick(); mid();
    chk("unal mem_en", mem_en, 0);
    chk("unal dm_done", dm_done, 1);
    chk("unal err", err, 1);
    tick(); dm_req = 1'b0;
    mid();
    chk("unal err pulse", err, 0);
    chk("unal done pulse", dm_done, 0);
    tick();

    // Halt during a store: access completes, then arbiter parks
    memLat = 3;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0060; dm_wdata = 16'hBEEF;
    mid(); tick(); mid();
    chk("halt store en", mem_en, 1);
    tick(); halt = 1'b1;
    mid(); chk("halt not yet", halted, 0);
    waitFor(1'b1, 20, n, got);
    chk("halt store done", got, 1);
    chk("halt store delay", n, 2);
    tick(); dm_req = 1'b0;
    mid(); chk("halt idle cycle", halted, 0);
    tick(); mid(); chk("halted set", halted, 1);
    tick(); halt = 1'b0; if_req = 1'b1; if_addr = 16'h0070;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (mem_en || if_done || dm_done || err || !halted) bad++;
      tick();
    end
    chk("halted absorbing", bad, 0);

    // Reset mid-fetch drops the access; the late mem_done is ignored
    rst_n = 1'b0; if_req = 1'b0;
    mid(); chk("reset clears halted", halted, 0);
    tick(); rst_n = 1'b1;
    mid(); tick();
    memLat = 5; if_req = 1'b1; if_addr = 16'h0050;
    mid(); tick(); mid();
    chk("rstmid en", mem_en, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rstmid mem_addr", mem_addr, 0);
    chk("rstmid mem_en", mem_en, 0);
    chk("rstmid if_done", if_done, 0);
    chk("rstmid err", err, 0);
    if_req = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); mid();
      if (if_done || mem_en) bad++;
    end
    chk("rstmid no late done", bad, 0);
    tick();

    // Randomized phase against the arbitration model
    memRandLat = 1'b1;
    prevIdle = 1'b1; pIf = 1'b0; pDm = 1'b0;
    busyCarry = 1'b0; carryKind = 0; lastDone = 0; waitModel = 0;
    for (int i = 0; i < 2000; i++) begin
      if (if_req) begin
        if (lastDone == 1) begin
          if ($urandom_range(0, 1) == 1) newIf(); else if_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) newIf();
      if (dm_req) begin
        if (lastDone == 2) begin
          if ($urandom_range(0, 1) == 1) newDm(); else dm_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) newDm();

      mid();
      grantKind = 0;
      if (prevIdle) begin
        if (pDm && !(pIf && waitModel == MAXW)) grantKind = 2;
        else if (pIf)                           grantKind = 1;
      end
      if (grantKind == 2 && pIf && waitModel < MAXW) waitModel++;
      if (grantKind == 1) waitModel = 0;

      unal  = (grantKind == 1) ? if_addr[0] : (grantKind == 2) ? dm_addr[0] : 1'b0;
      expEn = (grantKind != 0) && !unal;
      chk("rnd mem_en", mem_en, expEn);
      chk("rnd err", err, (grantKind != 0) && unal);
      if (expEn && grantKind == 2) begin
        chk("rnd dm addr", mem_addr, dm_addr);
        chk("rnd dm wr", mem_wr, dm_wr);
        chk("rnd dm wdata", mem_wdata, dm_wr ? dm_wdata : 16'h0000);
      end
      if (expEn && grantKind == 1) begin
        chk("rnd if addr", mem_addr, if_addr);
        chk("rnd if wr", mem_wr, 0);
        chk("rnd if wdata", mem_wdata, 0);
      end

      busyThis = (grantKind != 0) || busyCarry;
      kindThis = (grantKind != 0) ? grantKind : carryKind;
      doneNow  = busyThis && (((grantKind != 0) && unal) || mem_done);
      chk("rnd if_done", if_done, doneNow && kindThis == 1);
      chk("rnd dm_done", dm_done, doneNow && kindThis == 2);
      if (doneNow && !((grantKind != 0) && unal)) begin
        if (kindThis == 1) chk("rnd if rdata", rdata, expRead(if_addr));
        else if (!dm_wr)   chk("rnd dm rdata", rdata, expRead(dm_addr));
        else               shadow[dm_addr] = dm_wdata;
      end

      busyCarry = busyThis && !doneNow;
      carryKind = kindThis;
      prevIdle  = !busyThis;
      pIf       = if_req;
      pDm       = dm_req;
      lastDone  = doneNow ? kindThis : 0;
      tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 4, consecutive data grants tolerated while fetch waits (range 1..7).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: if_req  input  1  fetch request, level, held until if_done.
REQ-005 SHALL have port: if_addr  input  16  fetch word address, stable while if_req.
REQ-006 SHALL have port: if_done  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port: dm_req  input  1  data request, level, held until dm_done.
REQ-008 SHALL have port: dm_wr  input  1  1 = store, 0 = load; stable while dm_req.
REQ-009 SHALL have port: dm_addr  input  16  data address, stable while dm_req.
REQ-010 SHALL have port: dm_wdata  input  16  store data, stable while dm_req.
REQ-011 SHALL have port: dm_done  output  1  one-cycle data completion pulse.
REQ-012 SHALL have port: rdata  output  16  read data, valid only with if_done or dm_done (load).
REQ-013 SHALL have port: mem_en, mem_wr  output  1 each  shared-memory strobe and write select.
REQ-014 SHALL have port: mem_addr, mem_wdata  output  16 each  shared-memory address and write data.
REQ-015 SHALL have port: mem_rdata  input  16; mem_done  input  1  memory completion pulse.
REQ-016 SHALL have port: halt  input  1  stop issuing; halted  output  1  arbiter idle-locked; err  output  1  unaligned-access pulse.

Function
REQ-017 SHALL implement states IDLE, BUSY_IF, BUSY_DM, HALTED.
REQ-018 IDLE priority SHALL be: halt -> HALTED; else dm_req -> BUSY_DM; else if_req -> BUSY_IF; else IDLE.
REQ-019 SHALL override to BUSY_IF when if_req=1, dm_req=1 and wait_cnt == MAX_WAIT.
REQ-020 wait_cnt (3 bits) SHALL increment on each DM grant while if_req=1, clear on each IF grant, and saturate at MAX_WAIT.
REQ-021 mem_en, mem_wr, mem_addr, mem_wdata SHALL be registered and mem_en SHALL be high for exactly the first cycle of a BUSY state.
REQ-022 mem_wr SHALL be 0 for fetch; mem_wdata SHALL be 0 for fetch and loads.
REQ-023 In BUSY_x, x_done SHALL equal mem_done (combinational); rdata SHALL pass mem_rdata; next state SHALL be IDLE after mem_done.
REQ-024 Minimum request-to-done latency SHALL be 2 cycles (grant/issue cycle plus earliest mem_done); back-to-back grants SHALL be separated by one IDLE cycle.
REQ-025 A granted request with addr[0]=1 SHALL NOT assert mem_en; instead x_done and err SHALL pulse together in the first BUSY cycle, then IDLE.
REQ-026 mem_done outside BUSY states SHALL be ignored.
REQ-027 halt during BUSY SHALL NOT abort the access; HALTED SHALL be entered from the following IDLE cycle.
REQ-028 HALTED SHALL be absorbing until reset; halted=1, no grants, no done pulses.

Reset
REQ-029 On rst_n low, state SHALL become IDLE, wait_cnt 0, and mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, err, halted SHALL be 0 immediately.
REQ-030 Reset mid-access SHALL drop the transaction silently; no done pulse after release.

Structure
REQ-031 State encoding and MAX_WAIT default SHALL live in a shared package with the processor's other control constants.
REQ-032 The starvation counter SHALL be one sub-module, arb_wait_cnt; the FSM stays in mem_arb.
REQ-033 Estimated size: 150-250 lines RTL.

Verification
REQ-034 if_req only, if_addr=0x0010, mem_done 3 cycles after mem_en, mem_rdata=0xD0AF -> if_done pulse with rdata=0xD0AF, mem_wr=0.
REQ-035 if_req and dm_req (store 0x1234 to 0x0020) together -> DM issued first, IF issued after one IDLE cycle.
REQ-036 dm_req continuously re-asserted, if_req held, MAX_WAIT=4 -> exactly 4 DM grants, then IF granted.
REQ-037 dm_req load at 0x0021 -> no mem_en, dm_done and err pulse together in grant cycle.
REQ-038 halt asserted mid BUSY_DM -> dm_done delivered, then halted=1, later if_req ignored.
REQ-039 rst_n low during BUSY_IF -> outputs 0 asynchronously; after release, late mem_done produces no if_done.
